seg7_rx_monitor: RTL and testbench
==================================

Name: seg7_rx_monitor

Overview:
- Receive side of the board's seven-segment digit interface: samples an active-low 7-bit segment bus driven by the BCD counter/display path and filters out glitches.
- Decodes stable patterns back to a 4-bit digit and flags illegal patterns.
- Checks that successive digits follow the counting sequence (n -> n+1, 9 -> 0).
- Used as an on-board self-check / loopback monitor for counter-plus-decoder display paths.

Parameters:
- STABLE_CYCLES, 1000, consecutive identical synchronized samples required before a pattern is accepted (>=2).
- CNT_W, 8, width of the saturating sequence-error counter.

Ports:
- clock  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  high = filter and checker run; low = filter and state frozen.
- clear  input  1  synchronous; zeroes seq_err_count and drops sequence history.
- seg_n  input  7  segment bus, active-low; bit0 = a … bit6 = g.
- digit  output  4  last accepted decoded value.
- digit_valid  output  1  one-cycle pulse when a new legal digit is accepted.
- blank  output  1  level; high while the accepted pattern is all-off (7'h7F).
- pattern_err  output  1  one-cycle pulse when an illegal stable pattern is accepted.
- seq_err  output  1  one-cycle pulse when an accepted digit breaks the sequence.
- seq_err_count  output  CNT_W  saturating count of seq_err pulses.

Behaviour:
- Reset values: digit=0, digit_valid=0, blank=1, pattern_err=0, seq_err=0, seq_err_count=0. Internal state: sync regs=7'h7F, candidate=7'h7F, accepted=7'h7F, stable count=0, state=BLANK, has_prev=0.
- Input synchronizer: 2-FF on seg_n, always running, not gated by enable.
- Filter, when enable=1:
  - If sync_out != candidate: candidate<=sync_out, stable count<=0.
  - Else, if stable count < STABLE_CYCLES-1: stable count increments.
  - When stable count reaches STABLE_CYCLES-1 and candidate != accepted: pattern is accepted (accepted<=candidate).
  - A pattern equal to the current accepted one is never re-accepted.
- Filter, when enable=0: candidate, stable count and all outputs hold; pulses are forced to 0.
- Latency: a seg_n change held stable produces its pulse exactly STABLE_CYCLES+2 clocks after the change edge.
- Legal decode table (seg_n hex -> digit):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
  - 7F = blank.
  - Any other value is illegal.
- State machine (advances only on acceptance events):
  - BLANK: legal digit -> LOCKED (digit updated, digit_valid pulse, has_prev<=1, no sequence check); illegal -> FAULT.
  - LOCKED: legal digit -> stays LOCKED, digit_valid pulse, sequence check; blank -> BLANK (has_prev<=0); illegal -> FAULT (has_prev<=0).
  - FAULT: legal digit -> LOCKED (no sequence check); blank -> BLANK; another illegal pattern -> FAULT.
- blank output = (state==BLANK). Digit holds its last legal value through BLANK and FAULT.
- Sequence check: when has_prev=1 and a new legal digit arrives, the expected value is (prev==9 ? 0 : prev+1). On mismatch, seq_err pulses in the same cycle as digit_valid, and seq_err_count increments, saturating at all-ones.
- pattern_err pulses once per illegal acceptance. The digit value does not change.
- clear: seq_err_count<=0, has_prev<=0. Same-cycle acceptance still updates digit, but no sequence check is made and the count is not incremented (clear wins).
- Reset asserted mid-filter or mid-sequence: everything returns to reset values immediately. After release, the first legal digit never flags seq_err.

Optional Feature:
- Macro: SEG7_RX_HEX_EN.
- When defined:
  - Patterns 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F are legal.
  - Sequence wraps 15->0; 9->0 becomes a seq_err and 9->A is expected.
- When undefined:
  - These six patterns are illegal (pattern_err).
  - Sequence wraps 9->0.

Test Plan:
- STABLE_CYCLES=4; after reset drive 40 -> digit_valid at clock 6 after the change, digit=0, blank=0, seq_err=0.
- Drive 79, 24, 30 … 10, 40, each held 10 clocks -> ten digit_valid pulses 1..9,0 in order, seq_err never set, seq_err_count=0.
- With 30 (digit 3) accepted, glitch seg_n to 00 for 3 clocks, then back to 30 -> no pulse of any kind, digit stays 3.
- With 24 (digit 2) accepted, drive 19 (digit 4) -> digit_valid plus seq_err same cycle, seq_err_count=1. Repeat 255 more times with CNT_W=8 -> count saturates at 255; clear -> count 0.
- Drive 08 stable -> without macro: pattern_err pulse, digit unchanged, next legal digit raises no seq_err. With SEG7_RX_HEX_EN: digit=A, and 9->A raises no seq_err.
- enable=0 while 40 -> 79 change held 20 clocks -> no pulse. Raise enable -> pulse after STABLE_CYCLES clocks. Assert reset mid-count -> all outputs return to reset values, blank=1.

Source files
------------

// File: rtl/seg7_rx_monitor.sv
// seg7_rx_monitor: receive-side checker for an active-low seven-segment bus.
// Synchronizes and debounces seg_n, decodes accepted patterns back to a digit,
// flags illegal patterns and counts breaks in the n -> n+1 counting sequence.
// Optional build macro SEG7_RX_HEX_EN: accepts hex glyphs A..F and wraps the
// expected sequence at 15 instead of 9.
module seg7_rx_monitor #(
  parameter int STABLE_CYCLES = 1000,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [6:0]       seg_n,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic             pattern_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] seq_err_count
);

  localparam int SC_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] STABLE_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PK_DIGIT   = 2'd0,
    PK_BLANK   = 2'd1,
    PK_ILLEGAL = 2'd2
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [3:0] val;
  } dec_t;

  // Map an active-low segment pattern (bit0 = a .. bit6 = g) to a glyph class.
  function automatic dec_t decode(input logic [6:0] p);
    dec_t r;
    r.kind = PK_DIGIT;
    r.val  = 4'd0;
    case (p)
      7'h40: r.val = 4'd0;
      7'h79: r.val = 4'd1;
      7'h24: r.val = 4'd2;
      7'h30: r.val = 4'd3;
      7'h19: r.val = 4'd4;
      7'h12: r.val = 4'd5;
      7'h02: r.val = 4'd6;
      7'h78: r.val = 4'd7;
      7'h00: r.val = 4'd8;
      7'h10: r.val = 4'd9;
`ifdef SEG7_RX_HEX_EN
      7'h08: r.val = 4'hA;
      7'h03: r.val = 4'hB;
      7'h46: r.val = 4'hC;
      7'h21: r.val = 4'hD;
      7'h06: r.val = 4'hE;
      7'h0E: r.val = 4'hF;
`endif
      PAT_BLANK: r.kind = PK_BLANK;
      default:   r.kind = PK_ILLEGAL;
    endcase
    return r;
  endfunction

  // Successor of a digit in the counting sequence the display path produces.
  function automatic logic [3:0] next_digit(input logic [3:0] prev);
`ifdef SEG7_RX_HEX_EN
    return (prev == 4'hF) ? 4'd0 : prev + 4'd1;
`else
    return (prev == 4'd9) ? 4'd0 : prev + 4'd1;
`endif
  endfunction

  // Saturating increment: the error counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic [6:0]       sync1_q, sync1_d;
  logic [6:0]       sync2_q, sync2_d;
  logic [6:0]       cand_q, cand_d;
  logic [SC_W-1:0]  stable_q, stable_d;
  logic [6:0]       acc_q, acc_d;
  state_t           state_q, state_d;
  logic             has_prev_q, has_prev_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             pattern_err_q, pattern_err_d;
  logic             seq_err_q, seq_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  dec_t             dec;

  // Two-stage synchronizer; runs regardless of enable.
  always_comb begin
    sync1_d = seg_n;
    sync2_d = sync1_q;
  end

  // Debounce filter: a pattern must repeat STABLE_CYCLES samples to be accepted.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    accept   = 1'b0;
    if (enable) begin
      if (sync2_q != cand_q) begin
        cand_d   = sync2_q;
        stable_d = '0;
      end else begin
        if (stable_q < STABLE_LAST) begin
          stable_d = stable_q + SC_W'(1);
        end
        // Accept on the sample that completes the run so the pulse lands
        // STABLE_CYCLES+2 clocks after the bus change.
        if ((stable_d == STABLE_LAST) && (cand_q != acc_q)) begin
          accept = 1'b1;
        end
      end
    end
    acc_d = accept ? cand_q : acc_q;
  end

  // Display state machine and sequence checker, advanced only by acceptances.
  always_comb begin
    state_d       = state_q;
    has_prev_d    = has_prev_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    pattern_err_d = 1'b0;
    seq_err_d     = 1'b0;
    count_d       = count_q;
    dec           = decode(cand_q);
    if (accept) begin
      case (state_q)
        ST_BLANK: begin
          case (dec.kind)
            PK_DIGIT: begin
              state_d       = ST_LOCKED;
              digit_d       = dec.val;
              digit_valid_d = 1'b1;
              has_prev_d    = 1'b1;
            end
            PK_ILLEGAL: begin
              state_d       = ST_FAULT;
              pattern_err_d = 1'b1;
            end
            default: ;
          endcase
        end
        ST_LOCKED: begin
          case (dec.kind)
            PK_DIGIT: begin
              digit_d       = dec.val;
              digit_valid_d = 1'b1;
              has_prev_d    = 1'b1;
              // A same-cycle clear suppresses the check and the count.
              if (has_prev_q && !clear && (dec.val != next_digit(digit_q))) begin
                seq_err_d = 1'b1;
                count_d   = sat_inc(count_q);
              end
            end
            PK_BLANK: begin
              state_d    = ST_BLANK;
              has_prev_d = 1'b0;
            end
            PK_ILLEGAL: begin
              state_d       = ST_FAULT;
              pattern_err_d = 1'b1;
              has_prev_d    = 1'b0;
            end
            default: ;
          endcase
        end
        ST_FAULT: begin
          case (dec.kind)
            PK_DIGIT: begin
              state_d       = ST_LOCKED;
              digit_d       = dec.val;
              digit_valid_d = 1'b1;
              has_prev_d    = 1'b1;
            end
            PK_BLANK: begin
              state_d = ST_BLANK;
            end
            PK_ILLEGAL: begin
              pattern_err_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: state_d = ST_BLANK;
      endcase
    end
    if (clear) begin
      count_d    = '0;
      has_prev_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q       <= PAT_BLANK;
      sync2_q       <= PAT_BLANK;
      cand_q        <= PAT_BLANK;
      stable_q      <= '0;
      acc_q         <= PAT_BLANK;
      state_q       <= ST_BLANK;
      has_prev_q    <= 1'b0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      seq_err_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      acc_q         <= acc_d;
      state_q       <= state_d;
      has_prev_q    <= has_prev_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      pattern_err_q <= pattern_err_d;
      seq_err_q     <= seq_err_d;
      count_q       <= count_d;
    end
  end

  assign digit         = digit_q;
  assign digit_valid   = digit_valid_q;
  assign blank         = (state_q == ST_BLANK);
  assign pattern_err   = pattern_err_q;
  assign seq_err       = seq_err_q;
  assign seq_err_count = count_q;

endmodule

// File: tb/tb_seg7_rx_monitor.sv
// Directed bench for seg7_rx_monitor with STABLE_CYCLES=4, CNT_W=8.
module tb_seg7_rx_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic [6:0] seg_n = 7'h7F;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       pattern_err;
  logic       seq_err;
  logic [7:0] seq_err_count;

  int checks = 0;
  int errors = 0;

  int         n_dv, n_se, n_pe, first_dv, first_se;
  logic [3:0] dv_digit;

  seg7_rx_monitor #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .seg_n(seg_n), .digit(digit), .digit_valid(digit_valid), .blank(blank),
    .pattern_err(pattern_err), .seq_err(seq_err), .seq_err_count(seq_err_count)
  );

  always #5 clock = ~clock;

  // Drive a pattern for n clocks, tallying pulses sampled 1ns after each edge.
  task automatic hold(input logic [6:0] p, input int n);
    seg_n    = p;
    n_dv     = 0;
    n_se     = 0;
    n_pe     = 0;
    first_dv = -1;
    first_se = -1;
    dv_digit = 4'hX;
    for (int k = 1; k <= n; k++) begin
      @(posedge clock); #1;
      if (digit_valid === 1'b1) begin
        n_dv++;
        if (first_dv < 0) first_dv = k;
        dv_digit = digit;
      end
      if (seq_err === 1'b1) begin
        n_se++;
        if (first_se < 0) first_se = k;
      end
      if (pattern_err === 1'b1) n_pe++;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit got %0d want 0", digit); end
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", digit_valid); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b want 1", blank); end
    checks++; if (pattern_err !== 1'b0) begin errors++; $display("FAIL reset_pe got %b want 0", pattern_err); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_se got %b want 0", seq_err); end
    checks++; if (seq_err_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", seq_err_count); end
    reset = 1'b1;
  endtask

  task automatic test_first_digit();
    hold(7'h40, 10);
    checks++; if (first_dv !== 6) begin errors++; $display("FAIL first_latency got %0d want 6", first_dv); end
    checks++; if (n_dv !== 1) begin errors++; $display("FAIL first_dv_count got %0d want 1", n_dv); end
    checks++; if (dv_digit !== 4'd0) begin errors++; $display("FAIL first_digit got %0d want 0", dv_digit); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL first_blank got %b want 0", blank); end
    checks++; if (n_se !== 0) begin errors++; $display("FAIL first_seq_err got %0d want 0", n_se); end
  endtask

  task automatic test_count_sequence();
    logic [6:0] pats [10];
    int total_dv, total_se, exp_se;
    pats = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h40};
    total_dv = 0;
    total_se = 0;
    for (int i = 0; i < 10; i++) begin
      hold(pats[i], 10);
      total_dv += n_dv;
      total_se += n_se;
      checks++;
      if (dv_digit !== 4'((i + 1) % 10)) begin
        errors++; $display("FAIL seq_digit_%0d got %0d want %0d", i, dv_digit, (i + 1) % 10);
      end
    end
`ifdef SEG7_RX_HEX_EN
    exp_se = 1;
`else
    exp_se = 0;
`endif
    checks++; if (total_dv !== 10) begin errors++; $display("FAIL seq_dv_total got %0d want 10", total_dv); end
    checks++; if (total_se !== exp_se) begin errors++; $display("FAIL seq_se_total got %0d want %0d", total_se, exp_se); end
    checks++; if (seq_err_count !== 8'(exp_se)) begin errors++; $display("FAIL seq_count got %0d want %0d", seq_err_count, exp_se); end
  endtask

  task automatic test_glitch();
    int total;
    hold(7'h79, 10);
    hold(7'h24, 10);
    hold(7'h30, 10);
    checks++; if (digit !== 4'd3) begin errors++; $display("FAIL glitch_pre_digit got %0d want 3", digit); end
    hold(7'h00, 3);
    total = n_dv + n_se + n_pe;
    hold(7'h30, 10);
    total += n_dv + n_se + n_pe;
    checks++; if (total !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", total); end
    checks++; if (digit !== 4'd3) begin errors++; $display("FAIL glitch_digit got %0d want 3", digit); end
  endtask

  task automatic test_seq_error_saturate();
    int total_se;
    pulse_clear();
    checks++; if (seq_err_count !== 8'd0) begin errors++; $display("FAIL clear_count got %0d want 0", seq_err_count); end
    hold(7'h24, 10);
    checks++; if (n_se !== 0) begin errors++; $display("FAIL clear_history got %0d want 0", n_se); end
    hold(7'h19, 10);
    checks++; if (n_dv !== 1) begin errors++; $display("FAIL seqerr_dv got %0d want 1", n_dv); end
    checks++; if (first_se !== first_dv) begin errors++; $display("FAIL seqerr_same_cycle got %0d want %0d", first_se, first_dv); end
    checks++; if (dv_digit !== 4'd4) begin errors++; $display("FAIL seqerr_digit got %0d want 4", dv_digit); end
    checks++; if (seq_err_count !== 8'd1) begin errors++; $display("FAIL seqerr_count got %0d want 1", seq_err_count); end
    total_se = 0;
    for (int i = 0; i < 255; i++) begin
      hold((i % 2 == 0) ? 7'h24 : 7'h19, 8);
      total_se += n_se;
      if (i == 253) begin
        checks++; if (seq_err_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", seq_err_count); end
      end
    end
    checks++; if (total_se !== 255) begin errors++; $display("FAIL sat_pulses got %0d want 255", total_se); end
    checks++; if (seq_err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", seq_err_count); end
    pulse_clear();
    checks++; if (seq_err_count !== 8'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", seq_err_count); end
  endtask

  task automatic test_illegal_and_blank();
    pulse_clear();
    hold(7'h10, 10);
    checks++; if (dv_digit !== 4'd9) begin errors++; $display("FAIL ill_pre_digit got %0d want 9", dv_digit); end
    hold(7'h08, 10);
`ifdef SEG7_RX_HEX_EN
    checks++; if (n_pe !== 0) begin errors++; $display("FAIL hex_pe got %0d want 0", n_pe); end
    checks++; if (dv_digit !== 4'hA) begin errors++; $display("FAIL hex_digit got %0d want 10", dv_digit); end
    checks++; if (n_se !== 0) begin errors++; $display("FAIL hex_9_to_a got %0d want 0", n_se); end
    hold(7'h79, 10);
    checks++; if (n_se !== 1) begin errors++; $display("FAIL hex_a_to_1 got %0d want 1", n_se); end
`else
    checks++; if (n_pe !== 1) begin errors++; $display("FAIL ill_pe got %0d want 1", n_pe); end
    checks++; if (n_dv !== 0) begin errors++; $display("FAIL ill_dv got %0d want 0", n_dv); end
    checks++; if (digit !== 4'd9) begin errors++; $display("FAIL ill_digit got %0d want 9", digit); end
    checks++; if (blank !== 1'b0) begin errors++; $display("FAIL ill_blank got %b want 0", blank); end
    hold(7'h79, 10);
    checks++; if (n_se !== 0) begin errors++; $display("FAIL ill_next_se got %0d want 0", n_se); end
`endif
    checks++; if (dv_digit !== 4'd1) begin errors++; $display("FAIL ill_next_digit got %0d want 1", dv_digit); end
    hold(7'h7F, 10);
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL blank_level got %b want 1", blank); end
    checks++; if ((n_dv + n_pe + n_se) !== 0) begin errors++; $display("FAIL blank_pulses got %0d want 0", n_dv + n_pe + n_se); end
    checks++; if (digit !== 4'd1) begin errors++; $display("FAIL blank_digit got %0d want 1", digit); end
  endtask

  task automatic test_enable_and_reset();
    pulse_clear();
    hold(7'h40, 10);
    checks++; if (dv_digit !== 4'd0) begin errors++; $display("FAIL en_pre_digit got %0d want 0", dv_digit); end
    enable = 1'b0;
    hold(7'h79, 20);
    checks++; if ((n_dv + n_se + n_pe) !== 0) begin errors++; $display("FAIL en_frozen got %0d want 0", n_dv + n_se + n_pe); end
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL en_frozen_digit got %0d want 0", digit); end
    enable = 1'b1;
    hold(7'h79, 10);
    checks++; if (first_dv !== 4) begin errors++; $display("FAIL en_latency got %0d want 4", first_dv); end
    checks++; if (dv_digit !== 4'd1) begin errors++; $display("FAIL en_digit got %0d want 1", dv_digit); end
    checks++; if (n_se !== 0) begin errors++; $display("FAIL en_se got %0d want 0", n_se); end
    hold(7'h30, 10);
    checks++; if (seq_err_count !== 8'd1) begin errors++; $display("FAIL pre_reset_count got %0d want 1", seq_err_count); end
    hold(7'h24, 3);
    reset = 1'b0;
    #1;
    checks++; if (digit !== 4'd0) begin errors++; $display("FAIL rst_digit got %0d want 0", digit); end
    checks++; if (blank !== 1'b1) begin errors++; $display("FAIL rst_blank got %b want 1", blank); end
    checks++; if (seq_err_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d want 0", seq_err_count); end
    checks++; if ((digit_valid | seq_err | pattern_err) !== 1'b0) begin errors++; $display("FAIL rst_pulses got %b want 0", digit_valid | seq_err | pattern_err); end
    @(posedge clock); #1;
    reset = 1'b1;
    hold(7'h30, 10);
    checks++; if (first_dv !== 6) begin errors++; $display("FAIL post_rst_latency got %0d want 6", first_dv); end
    checks++; if (dv_digit !== 4'd3) begin errors++; $display("FAIL post_rst_digit got %0d want 3", dv_digit); end
    checks++; if (n_se !== 0) begin errors++; $display("FAIL post_rst_se got %0d want 0", n_se); end
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_count_sequence();
    test_glitch();
    test_seq_error_saturate();
    test_illegal_and_blank();
    test_enable_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
